// File: rtl/shift_pkg.sv
// Shared definitions for the shift scheduler: op and state encodings plus datapath widths.
package shift_pkg;
  localparam int DATA_W = 4;
  localparam int AMT_W  = 3;

  localparam logic [1:0] OP_SHL = 2'b00;
  localparam logic [1:0] OP_SHR = 2'b01;
  localparam logic [1:0] OP_ROL = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS1 = 2'd1,
    ST_PASS2 = 2'd2,
    ST_RESP  = 2'd3
  } state_t;
endpackage

// File: rtl/barrel_shifter.sv
// Zero-filling logical shifter; dir 0 shifts left, 1 shifts right.
module barrel_shifter
  import shift_pkg::*;
(
  input  logic [DATA_W-1:0] data,
  input  logic [AMT_W-1:0]  amt,
  input  logic              dir,
  output logic [DATA_W-1:0] result
);

  // Amounts of a full word or more clear every bit.
  always_comb begin
    result = '0;
    if (amt < AMT_W'(DATA_W)) begin
      result = dir ? (data >> amt) : (data << amt);
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin picker: searches from ptr+1 with wrap and returns a one-hot grant and its index.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               found
);

  // Outer loop walks priority order, so the first hit is the nearest requester after ptr.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && req[j] && (((int'(ptr) + i) % NUM_REQ) == j)) begin
          found    = 1'b1;
          grant[j] = 1'b1;
          idx      = ID_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/shift_scheduler.sv
// Time-shares one barrel shifter between NUM_REQ requesters; rotates take two passes OR-ed together.
module shift_scheduler
  import shift_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [DATA_W*NUM_REQ-1:0] req_data,
  input  logic [AMT_W*NUM_REQ-1:0]  req_amt,
  input  logic [2*NUM_REQ-1:0]      req_op,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [ID_W-1:0]           out_id,
  output logic                      busy
);

  state_t              state, state_next;
  logic [ID_W-1:0]     rr_ptr, grant_idx, id_q;
  logic [NUM_REQ-1:0]  grant;
  logic                grant_found;
  logic [DATA_W-1:0]   data_q, acc, sh_out;
  logic [AMT_W-1:0]    amt_q, sh_amt;
  logic [1:0]          op_q, rot_amt;
  logic                sh_dir, is_rot;

  assign rot_amt  = amt_q[1:0];
  assign is_rot   = op_q[1];
  assign out_data = acc;
  assign out_id   = id_q;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (grant_idx),
    .found (grant_found)
  );

  // Rotate = shift by r one way, then by 4-r the other way, OR-ed.
  always_comb begin
    sh_amt = amt_q;
    sh_dir = op_q[0];
    if (is_rot) begin
      if (state == ST_PASS2) begin
        sh_amt = 3'd4 - {1'b0, rot_amt};
        sh_dir = ~op_q[0];
      end else begin
        sh_amt = {1'b0, rot_amt};
      end
    end
  end

  barrel_shifter u_shift (
    .data   (data_q),
    .amt    (sh_amt),
    .dir    (sh_dir),
    .result (sh_out)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = '0;
    out_valid  = 1'b0;
    busy       = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (grant_found) begin
          req_ready  = grant;
          state_next = ST_PASS1;
        end
      end
      ST_PASS1: state_next = (is_rot && rot_amt != 2'd0) ? ST_PASS2 : ST_RESP;
      ST_PASS2: state_next = ST_RESP;
      ST_RESP: begin
        out_valid = 1'b1;
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Operand capture on grant and accumulator updates per pass.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= ID_W'(NUM_REQ - 1);
      data_q <= '0;
      amt_q  <= '0;
      op_q   <= '0;
      id_q   <= '0;
      acc    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_found) begin
            data_q <= req_data[grant_idx*DATA_W +: DATA_W];
            amt_q  <= req_amt[grant_idx*AMT_W +: AMT_W];
            op_q   <= req_op[grant_idx*2 +: 2];
            id_q   <= grant_idx;
            rr_ptr <= grant_idx;
          end
        end
        ST_PASS1: acc <= (is_rot && rot_amt == 2'd0) ? data_q : sh_out;
        ST_PASS2: acc <= acc | sh_out;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_scheduler.sv
// Directed self-checking bench for shift_scheduler with two requesters.
module tb_shift_scheduler;
  localparam int NUM_REQ = 2;
  localparam int ID_W    = 1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NUM_REQ-1:0] req_valid = '0;
  logic [NUM_REQ-1:0] req_ready;
  logic [4*NUM_REQ-1:0] req_data = '0;
  logic [3*NUM_REQ-1:0] req_amt = '0;
  logic [2*NUM_REQ-1:0] req_op = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [3:0]         out_data;
  logic [ID_W-1:0]    out_id;
  logic               busy;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int         id;
    logic [3:0] d;
    logic [2:0] a;
    logic [1:0] op;
    logic [3:0] exp;
    int         lat;
  } vec_t;

  shift_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_data(req_data), .req_amt(req_amt), .req_op(req_op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_id(out_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic set_req(input int i, input logic [3:0] d, input logic [2:0] a, input logic [1:0] op);
    req_data[4*i +: 4] = d;
    req_amt[3*i +: 3]  = a;
    req_op[2*i +: 2]   = op;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '0;
    out_ready = 1'b0;
    tick();
    tick();
    settle();
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL reset_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("[TB] FAIL reset_req_ready: got %b want 00", req_ready); end
    n_cmp++; if ({out_data, out_id} !== 5'b0) begin n_err++; $display("[TB] FAIL reset_out: got data %b id %0d want 0000 id 0", out_data, out_id); end
    n_cmp++; if (dut.rr_ptr !== 1'b1) begin n_err++; $display("[TB] FAIL reset_rr_ptr: got %0d want 1", dut.rr_ptr); end
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_single_ops();
    vec_t tab [7];
    tab[0] = '{0, 4'b1011, 3'd1, 2'b00, 4'b0110, 2};
    tab[1] = '{1, 4'b1001, 3'd1, 2'b10, 4'b0011, 3};
    tab[2] = '{0, 4'b0001, 3'd5, 2'b11, 4'b1000, 3};
    tab[3] = '{1, 4'b1111, 3'd6, 2'b01, 4'b0000, 2};
    tab[4] = '{0, 4'b1010, 3'd4, 2'b10, 4'b1010, 2};
    tab[5] = '{1, 4'b0110, 3'd0, 2'b01, 4'b0110, 2};
    tab[6] = '{0, 4'b0110, 3'd2, 2'b11, 4'b1001, 3};
    for (int k = 0; k < 7; k++) begin
      logic [1:0] exp_rdy;
      exp_rdy = '0;
      exp_rdy[tab[k].id] = 1'b1;
      tick();
      set_req(tab[k].id, tab[k].d, tab[k].a, tab[k].op);
      req_valid = exp_rdy;
      settle();
      n_cmp++; if (req_ready !== exp_rdy) begin n_err++; $display("[TB] FAIL op%0d_grant: got %b want %b", k, req_ready, exp_rdy); end
      tick();
      req_valid = '0;
      for (int c = 1; c < tab[k].lat; c++) begin
        settle();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL op%0d_early_valid cycle T+%0d: got %b want 0", k, c, out_valid); end
        tick();
      end
      settle();
      n_cmp++;
      if ({out_valid, out_data, out_id} !== {1'b1, tab[k].exp, ID_W'(tab[k].id)}) begin
        n_err++;
        $display("[TB] FAIL op%0d_result at T+%0d: got valid %b data %b id %0d want valid 1 data %b id %0d",
                 k, tab[k].lat, out_valid, out_data, out_id, tab[k].exp, tab[k].id);
      end
      tick();
      settle();
      n_cmp++; if ({out_valid, busy} !== 2'b00) begin n_err++; $display("[TB] FAIL op%0d_done: got valid %b busy %b want 0 0", k, out_valid, busy); end
    end
  endtask

  task automatic test_round_robin();
    int order [4];
    int ng = 0;
    int both = 0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    set_req(0, 4'b0001, 3'd1, 2'b00);
    set_req(1, 4'b0010, 3'd1, 2'b00);
    req_valid = 2'b11;
    for (int c = 0; c < 12; c++) begin
      settle();
      if ($countones(req_ready) > 1) both++;
      if (req_ready != 2'b00 && ng < 4) begin
        order[ng] = req_ready[1] ? 1 : 0;
        ng++;
      end
      tick();
    end
    req_valid = '0;
    n_cmp++; if (ng !== 4) begin n_err++; $display("[TB] FAIL rr_grant_count: got %0d want 4", ng); end
    for (int i = 0; i < ng; i++) begin
      n_cmp++; if (order[i] !== i % 2) begin n_err++; $display("[TB] FAIL rr_order[%0d]: got %0d want %0d", i, order[i], i % 2); end
    end
    n_cmp++; if (both !== 0) begin n_err++; $display("[TB] FAIL rr_onehot: got %0d double grants want 0", both); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    set_req(1, 4'b0011, 3'd1, 2'b00);
    req_valid = 2'b10;
    settle();
    n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("[TB] FAIL bp_grant: got %b want 10", req_ready); end
    tick();
    set_req(0, 4'b0101, 3'd0, 2'b00);
    req_valid = 2'b01;
    settle();
    n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("[TB] FAIL bp_pass1_ready: got %b want 00", req_ready); end
    tick();
    for (int c = 0; c < 5; c++) begin
      settle();
      n_cmp++;
      if ({out_valid, out_data, out_id, req_ready} !== {1'b1, 4'b0110, 1'b1, 2'b00}) begin
        n_err++;
        $display("[TB] FAIL bp_hold%0d: got valid %b data %b id %0d ready %b want 1 0110 1 00",
                 c, out_valid, out_data, out_id, req_ready);
      end
      tick();
    end
    out_ready = 1'b1;
    settle();
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("[TB] FAIL bp_release_valid: got %b want 1", out_valid); end
    tick();
    settle();
    n_cmp++; if ({out_valid, req_ready} !== 3'b001) begin n_err++; $display("[TB] FAIL bp_after: got valid %b ready %b want 0 01", out_valid, req_ready); end
    tick();
    req_valid = '0;
    tick();
    settle();
    n_cmp++;
    if ({out_valid, out_data, out_id} !== {1'b1, 4'b0101, 1'b0}) begin
      n_err++;
      $display("[TB] FAIL bp_next_result: got valid %b data %b id %0d want 1 0101 0", out_valid, out_data, out_id);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    set_req(0, 4'b1001, 3'd1, 2'b10);
    req_valid = 2'b01;
    settle();
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("[TB] FAIL rm_grant: got %b want 01", req_ready); end
    tick();
    req_valid = '0;
    tick();
    rst = 1'b1;
    settle();
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("[TB] FAIL rm_pass2_busy: got %b want 1", busy); end
    tick();
    rst = 1'b0;
    set_req(0, 4'b0001, 3'd2, 2'b00);
    set_req(1, 4'b1111, 3'd0, 2'b01);
    req_valid = 2'b11;
    settle();
    n_cmp++; if ({busy, out_valid} !== 2'b00) begin n_err++; $display("[TB] FAIL rm_after_busy_valid: got %b%b want 00", busy, out_valid); end
    n_cmp++; if (dut.rr_ptr !== 1'b1) begin n_err++; $display("[TB] FAIL rm_rr_ptr: got %0d want 1", dut.rr_ptr); end
    n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("[TB] FAIL rm_first_grant: got %b want 01", req_ready); end
    tick();
    req_valid = '0;
    settle();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("[TB] FAIL rm_stale_resp: got %b want 0", out_valid); end
    tick();
    settle();
    n_cmp++;
    if ({out_valid, out_data, out_id} !== {1'b1, 4'b0100, 1'b0}) begin
      n_err++;
      $display("[TB] FAIL rm_new_result: got valid %b data %b id %0d want 1 0100 0", out_valid, out_data, out_id);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_single_ops();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
